// File: rtl/decoder_xotr_01xxx11_seq_if.sv
// Bus bundle between the XOTR prefix logic / memory side and the sequenced 01xxx11x decoder.
interface decoder_xotr_01xxx11_seq_if #(
  parameter int unsigned PHASE_W = 5
);
  logic               start;
  logic [7:0]         opcode;
  logic               flush;
  logic               mem_ready;
  logic               busy;
  logic [PHASE_W-1:0] phase;
  logic [1:0]         im;
  logic               ld_i_a;
  logic               ld_r_a;
  logic               ld_a_i;
  logic               ld_a_r;
  logic               rrd;
  logic               rld;
  logic               flag_wr;
  logic               mem_rd;
  logic               mem_wr;
  logic               done;
  logic               err;

  modport master (
    output start, opcode, flush, mem_ready,
    input  busy, phase, im, ld_i_a, ld_r_a, ld_a_i, ld_a_r,
           rrd, rld, flag_wr, mem_rd, mem_wr, done, err
  );

  modport slave (
    input  start, opcode, flush, mem_ready,
    output busy, phase, im, ld_i_a, ld_r_a, ld_a_i, ld_a_r,
           rrd, rld, flag_wr, mem_rd, mem_wr, done, err
  );
endinterface

// File: rtl/decoder_xotr_01xxx11_seq.sv
// Sequenced ED-page 01xxx11x decoder: latches the opcode, walks EXEC/MRD/ALU/MWR/DONE
// and emits registered per-phase strobes, IM register, memory handshake and completion.
module decoder_xotr_01xxx11_seq #(
  parameter int unsigned PHASE_W    = 5,
  parameter int unsigned ALU_CYCLES = 4,
  parameter int unsigned WAIT_MAX   = 16,
  parameter int unsigned IM_RESET   = 0
) (
  input logic                         clk,
  input logic                         notReset,
  decoder_xotr_01xxx11_seq_if.slave   bus
);
  localparam int unsigned CNT_MAX = (WAIT_MAX > ALU_CYCLES) ? WAIT_MAX : ALU_CYCLES;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

  typedef enum logic [2:0] {S_IDLE, S_EXEC, S_MRD, S_ALU, S_MWR, S_DONE} state_e;
  typedef enum logic [2:0] {K_NOP, K_IM, K_LD_IA, K_LD_RA, K_LD_AI, K_LD_AR, K_RRD, K_RLD} kind_e;

  state_e             state;
  logic [7:0]         op_q;
  logic [PHASE_W-1:0] phase_q;
  logic [CNT_W-1:0]   cnt;
  logic [1:0]         im_q;
  logic busy_q, ld_i_a_q, ld_r_a_q, ld_a_i_q, ld_a_r_q, rrd_q, rld_q;
  logic flag_wr_q, mem_rd_q, mem_wr_q, done_q, err_q;

  function automatic kind_e decode(input logic [7:0] op);
    kind_e k;
    k = K_NOP;
    if (op[7:6] == 2'b01 && op[2:1] == 2'b11) begin
      if (!op[0]) k = K_IM;
      else begin
        case (op[5:3])
          3'd0:    k = K_LD_IA;
          3'd1:    k = K_LD_RA;
          3'd2:    k = K_LD_AI;
          3'd3:    k = K_LD_AR;
          3'd4:    k = K_RRD;
          3'd5:    k = K_RLD;
          default: k = K_NOP;
        endcase
      end
    end
    return k;
  endfunction

  function automatic logic [1:0] im_mode(input logic [7:0] op);
    case (op[4:3])
      2'b10:   return 2'd1;
      2'b11:   return 2'd2;
      default: return 2'd0;
    endcase
  endfunction

  function automatic logic [PHASE_W-1:0] sat_inc(input logic [PHASE_W-1:0] p);
    return (&p) ? p : p + PHASE_W'(1);
  endfunction

  kind_e start_kind, op_kind;
  assign start_kind = decode(bus.opcode);
  assign op_kind    = decode(op_q);

  // Outputs are computed for the state being entered, so every strobe is a flop.
  always_ff @(posedge clk or negedge notReset) begin
    if (!notReset) begin
      state     <= S_IDLE;
      op_q      <= '0;
      phase_q   <= '0;
      cnt       <= '0;
      im_q      <= 2'(IM_RESET);
      busy_q    <= 1'b0;
      ld_i_a_q  <= 1'b0;
      ld_r_a_q  <= 1'b0;
      ld_a_i_q  <= 1'b0;
      ld_a_r_q  <= 1'b0;
      rrd_q     <= 1'b0;
      rld_q     <= 1'b0;
      flag_wr_q <= 1'b0;
      mem_rd_q  <= 1'b0;
      mem_wr_q  <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      ld_i_a_q  <= 1'b0;
      ld_r_a_q  <= 1'b0;
      ld_a_i_q  <= 1'b0;
      ld_a_r_q  <= 1'b0;
      rrd_q     <= 1'b0;
      rld_q     <= 1'b0;
      flag_wr_q <= 1'b0;
      mem_rd_q  <= 1'b0;
      mem_wr_q  <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      if (bus.flush) begin
        state   <= S_IDLE;
        busy_q  <= 1'b0;
        phase_q <= '0;
        cnt     <= '0;
      end else begin
        case (state)
          S_IDLE, S_DONE: begin
            if (bus.start) begin
              state     <= S_EXEC;
              op_q      <= bus.opcode;
              busy_q    <= 1'b1;
              phase_q   <= '0;
              cnt       <= '0;
              ld_i_a_q  <= (start_kind == K_LD_IA);
              ld_r_a_q  <= (start_kind == K_LD_RA);
              ld_a_i_q  <= (start_kind == K_LD_AI);
              ld_a_r_q  <= (start_kind == K_LD_AR);
              flag_wr_q <= (start_kind == K_LD_AI) || (start_kind == K_LD_AR);
            end else begin
              state   <= S_IDLE;
              busy_q  <= 1'b0;
              phase_q <= '0;
            end
          end
          S_EXEC: begin
            phase_q <= sat_inc(phase_q);
            cnt     <= '0;
            if (op_kind == K_RRD || op_kind == K_RLD) begin
              state    <= S_MRD;
              mem_rd_q <= 1'b1;
            end else begin
              if (op_kind == K_IM) im_q <= im_mode(op_q);
              state  <= S_DONE;
              done_q <= 1'b1;
            end
          end
          S_MRD, S_MWR: begin
            if (bus.mem_ready) begin
              phase_q <= sat_inc(phase_q);
              cnt     <= '0;
              if (state == S_MRD) begin
                state     <= S_ALU;
                rrd_q     <= (op_kind == K_RRD);
                rld_q     <= (op_kind == K_RLD);
                flag_wr_q <= (ALU_CYCLES == 1);
              end else begin
                state  <= S_DONE;
                done_q <= 1'b1;
              end
            end else if (cnt == CNT_W'(WAIT_MAX - 1)) begin
              // Timeout: the err cycle is already IDLE.
              state   <= S_IDLE;
              busy_q  <= 1'b0;
              phase_q <= '0;
              cnt     <= '0;
              err_q   <= 1'b1;
            end else begin
              phase_q  <= sat_inc(phase_q);
              cnt      <= cnt + CNT_W'(1);
              mem_rd_q <= (state == S_MRD);
              mem_wr_q <= (state == S_MWR);
            end
          end
          S_ALU: begin
            phase_q <= sat_inc(phase_q);
            if (cnt == CNT_W'(ALU_CYCLES - 1)) begin
              state    <= S_MWR;
              cnt      <= '0;
              mem_wr_q <= 1'b1;
            end else begin
              cnt       <= cnt + CNT_W'(1);
              flag_wr_q <= (cnt + CNT_W'(1) == CNT_W'(ALU_CYCLES - 1));
            end
          end
          default: begin
            state   <= S_IDLE;
            busy_q  <= 1'b0;
            phase_q <= '0;
          end
        endcase
      end
    end
  end

  assign bus.busy    = busy_q;
  assign bus.phase   = phase_q;
  assign bus.im      = im_q;
  assign bus.ld_i_a  = ld_i_a_q;
  assign bus.ld_r_a  = ld_r_a_q;
  assign bus.ld_a_i  = ld_a_i_q;
  assign bus.ld_a_r  = ld_a_r_q;
  assign bus.rrd     = rrd_q;
  assign bus.rld     = rld_q;
  assign bus.flag_wr = flag_wr_q;
  assign bus.mem_rd  = mem_rd_q;
  assign bus.mem_wr  = mem_wr_q;
  assign bus.done    = done_q;
  assign bus.err     = err_q;
endmodule

// File: doc/decoder_xotr_01xxx11_seq.md
# decoder_xotr_01xxx11_seq

Sequenced successor to the combinational XOTR 01xxx11x decoder. Latches an ED-prefixed opcode of the form 01xxx11x and steps it through execution phases with an internal phase counter:
- holds the interrupt-mode register;
- runs the memory read/write handshake for RRD/RLD, with a timeout;
- emits one-cycle control strobes per phase;
- emits a single completion pulse that stands for the former Reset-XPT / Set-CM1 / Reset-XOTR / Ophd group.

It sits between the XOTR prefix logic and the register/ALU/bus control planes.

## Interface
- PHASE_W, 5, phase counter width. It saturates at 2^PHASE_W-1.
- ALU_CYCLES, 4, length of the RRD/RLD nibble-rotate phase in cycles. Legal range is 1 or more.
- WAIT_MAX, 16, maximum cycles spent in a memory phase before abort.
- IM_RESET, 0, interrupt mode loaded at reset (0..2).

Ports (name, direction, width, meaning):
- clk  in  1  clock; all state changes on the rising edge
- notReset  in  1  asynchronous, active-low reset
- start  in  1  opcode byte valid. Accepted only in IDLE or DONE.
- opcode  in  8  ED-page opcode. Sampled only when start is accepted.
- flush  in  1  synchronous abort to IDLE. No done, no err.
- mem_ready  in  1  bus cycle complete (read data valid / write accepted)
- busy  out  1  state is not IDLE
- phase  out  PHASE_W  cycles since acceptance. 0 in the first busy cycle.
- im  out  2  interrupt mode register
- ld_i_a, ld_r_a, ld_a_i, ld_a_r  out  1 each  register-transfer strobes
- rrd, rld  out  1 each  ALU rotate strobes
- flag_wr  out  1  write S/Z/PV, clear H/N
- mem_rd, mem_wr  out  1 each  bus request. Level, held until mem_ready.
- done  out  1  one-cycle completion pulse
- err  out  1  one-cycle timeout pulse

## Operation

States: IDLE, EXEC, MRD, ALU, MWR, DONE.

Decode of the latched opcode:
- bit0=0 is IM. New mode from bits[4:3]: 00→0, 01→0, 10→1, 11→2.
- bit0=1 uses bits[5:3]:
  - 000 LD I,A
  - 001 LD R,A
  - 010 LD A,I
  - 011 LD A,R
  - 100 RRD
  - 101 RLD
  - 110 and 111 NOP
- Opcodes with bits[7:6]≠01 or bits[2:1]≠11 are treated as NOP.

Transitions:
- IDLE/DONE + start → latch opcode, go to EXEC.
- DONE without start → IDLE.
- EXEC, by operation:
  - IM: im is updated at the end of EXEC, then DONE.
  - LD: the matching ld_* strobe is high in EXEC, then DONE. flag_wr is also high in EXEC for LD A,I and LD A,R.
  - NOP: no strobe, then DONE.
  - RRD/RLD: go to MRD.
- MRD: mem_rd=1. If mem_ready is sampled high, go to ALU.
- ALU: lasts ALU_CYCLES cycles.
  - rrd or rld is high in the first ALU cycle only.
  - flag_wr is high in the last ALU cycle. With ALU_CYCLES=1, both fall in the same cycle.
  - Then go to MWR.
- MWR: mem_wr=1. If mem_ready is sampled high, go to DONE.
- DONE: done=1 for exactly one cycle.

Memory timeout:
- A per-phase wait counter is cleared on entry to MRD or MWR.
- If mem_ready is still low after WAIT_MAX cycles in that state: err=1 for one cycle, go to IDLE, no done. The err cycle is itself IDLE.

Other rules:
- flush has priority over every transition, including a same-cycle start. No strobe is emitted in the next cycle.
- start is ignored in EXEC, MRD, ALU and MWR.

Reset (notReset low, asynchronous):
- State → IDLE; phase, wait counter and latched opcode → 0.
- im → IM_RESET.
- All strobes, mem_rd, mem_wr, done, err, busy → 0.
- A transaction in progress is lost.

## Timing
- Cycle 0 is the cycle in which start is sampled. EXEC occupies cycle 1, with phase=0.
- IM / LD / NOP:
  - done in cycle 2 (phase=1); busy in cycles 1–2.
  - A start in cycle 2 chains directly to EXEC in cycle 3 with phase=0.
- RRD/RLD with mem_ready held high:
  - MRD in cycle 2.
  - ALU in cycles 3..2+ALU_CYCLES.
  - MWR in cycle 3+ALU_CYCLES.
  - done in cycle 4+ALU_CYCLES. With defaults that is cycle 8, phase=7.
  - Each cycle of mem_ready low inserts one cycle.
- im changes on the edge that ends EXEC. It is visible in cycle 2.
- Phase counter:
  - increments every busy cycle;
  - reset to 0 on acceptance;
  - holds at all-ones on saturation;
  - is 0 in IDLE.
- All outputs are registered or decoded from registered state only. mem_ready never combinationally drives a strobe.

## Test plan
- Reset and IM:
  - After reset, im=IM_RESET=0.
  - start with opcode 0x5E → im=2 in cycle 2, done in cycle 2.
  - Then 0x56 → im=1; then 0x4E → im=0.
- LD A,R (0x5F) → ld_a_r=1 and flag_wr=1 in cycle 1 only, done in cycle 2. Immediately chaining 0x47 → ld_i_a in cycle 3.
- RRD (0x67) with defaults, mem_ready high except low during cycles 2–3 → mem_rd in cycles 2–4, rrd in cycle 5, flag_wr in cycle 8, mem_wr in cycle 9, done in cycle 10 with phase=9.
- RLD (0x6F) with mem_ready never asserted, WAIT_MAX=16 → mem_rd for 16 cycles, then err=1, busy=0, and done never asserts.
- Abort and reset during RLD:
  - flush asserted in the second ALU cycle → IDLE next cycle, no mem_wr, no done.
  - Rerun, dropping notReset mid-ALU → all outputs 0 asynchronously, im=IM_RESET.
- NOP opcodes 0x77 and 0x7F → no strobes, done in cycle 2. A start during busy is ignored and the latched opcode is unchanged.
